// File: rtl/imu_spi_responder.sv
// rtl/imu_spi_responder.sv - SPI mode-3 register responder for an IMU (optional macro IMU_RESP_AUTOINC_EN)
module imu_spi_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        SPC,
  input  logic        SDI,
  output logic        SDO,
  input  logic [95:0] sample,
  input  logic        sample_valid,
  output logic [79:0] ctrl_regs,
  output logic        txn_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state;
  logic        cs_s1, cs_s2, cs_q;
  logic        spc_s1, spc_s2, spc_q;
  logic        sdi_s1, sdi_s2;
  logic        warm1, warm2;
  logic        armed;
  logic [2:0]  cnt_q;
  logic [6:0]  sh_q;
  logic [7:0]  tx_q;
  logic        rw_q;
  logic [6:0]  addr_q;
  logic [95:0] shadow_q;
  logic [95:0] pend_q;
  logic        pend_flag;

  logic        cs_fall, cs_rise, spc_rise, spc_fall;
  logic [7:0]  rx_byte;
  logic [6:0]  next_addr;
  logic [6:0]  look;
  logic [7:0]  rd_byte;

  assign cs_fall  = cs_q & ~cs_s2;
  assign cs_rise  = ~cs_q & cs_s2;
  assign spc_rise = ~spc_q & spc_s2;
  assign spc_fall = spc_q & ~spc_s2;
  assign rx_byte  = {sh_q, sdi_s2};

`ifdef IMU_RESP_AUTOINC_EN
  assign next_addr = addr_q + 7'd1;
`else
  assign next_addr = addr_q;
`endif

  // The command byte supplies the first read address; afterwards the following address is prefetched.
  assign look = (state == CMD) ? rx_byte[6:0] : next_addr;

  // Two-flop synchronizers plus a warm-up pipe telling when cs_s2 reflects the real pin again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_q   <= 1'b1;
      spc_s1 <= 1'b1;
      spc_s2 <= 1'b1;
      spc_q  <= 1'b1;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
      warm1  <= 1'b0;
      warm2  <= 1'b0;
    end else begin
      cs_s1  <= CS;
      cs_s2  <= cs_s1;
      cs_q   <= cs_s2;
      spc_s1 <= SPC;
      spc_s2 <= spc_s1;
      spc_q  <= spc_s2;
      sdi_s1 <= SDI;
      sdi_s2 <= sdi_s1;
      warm1  <= 1'b1;
      warm2  <= warm1;
    end
  end

  // Register map lookup for the byte to be loaded into the transmit shifter.
  always_comb begin
    rd_byte = 8'h00;
    if (look == 7'h0F) rd_byte = 8'h6C;
    for (int i = 0; i < 10; i++)
      if (look == 7'(16 + i)) rd_byte = ctrl_regs[79 - 8*i -: 8];
    for (int i = 0; i < 12; i++)
      if (look == 7'(34 + i)) rd_byte = shadow_q[95 - 8*i -: 8];
  end

  // Transaction FSM with command decode, read shifting, write commit and sample shadowing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      SDO       <= 1'b0;
      txn_done  <= 1'b0;
      ctrl_regs <= '0;
      shadow_q  <= '0;
      pend_q    <= '0;
      pend_flag <= 1'b0;
      armed     <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      txn_done <= 1'b0;
      // A CS fall only counts once CS has been seen high after reset.
      if (warm2 && cs_s2) armed <= 1'b1;
      case (state)
        IDLE: begin
          SDO <= 1'b0;
          if (cs_fall && armed) begin
            state <= CMD;
            cnt_q <= '0;
            sh_q  <= '0;
            tx_q  <= '0;
            if (sample_valid) begin
              pend_q    <= sample;
              pend_flag <= 1'b1;
            end
          end else if (sample_valid) begin
            shadow_q <= sample;
          end
        end
        CMD, DATA: begin
          if (cs_rise) begin
            state    <= IDLE;
            SDO      <= 1'b0;
            txn_done <= (state == DATA);
            if (sample_valid)   shadow_q <= sample;
            else if (pend_flag) shadow_q <= pend_q;
            pend_flag <= 1'b0;
          end else begin
            if (sample_valid) begin
              pend_q    <= sample;
              pend_flag <= 1'b1;
            end
            if (spc_rise) begin
              sh_q  <= rx_byte[6:0];
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (state == CMD) begin
                  state  <= DATA;
                  rw_q   <= rx_byte[7];
                  addr_q <= rx_byte[6:0];
                  tx_q   <= rx_byte[7] ? rd_byte : 8'h00;
                end else begin
                  if (!rw_q) begin
                    for (int i = 0; i < 10; i++)
                      if (addr_q == 7'(16 + i)) ctrl_regs[79 - 8*i -: 8] <= rx_byte;
                  end else begin
                    tx_q <= rd_byte;
                  end
                  addr_q <= next_addr;
                end
              end
            end else if (spc_fall && state == DATA) begin
              SDO  <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_responder.sv
// tb/tb_imu_spi_responder.sv - self-checking bench for imu_spi_responder
module tb_imu_spi_responder;

  localparam int HALF = 8;
`ifdef IMU_RESP_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  localparam logic [95:0] SEQ = 96'h0102030405060708090A0B0C;

  logic        clk = 1'b0;
  logic        rst_n, cs, spc, sdi, sdo, sample_valid, txn_done;
  logic [95:0] sample;
  logic [79:0] ctrl_regs;

  always #5 clk = ~clk;

  imu_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .CS(cs), .SPC(spc), .SDI(sdi), .SDO(sdo),
    .sample(sample), .sample_valid(sample_valid), .ctrl_regs(ctrl_regs), .txn_done(txn_done)
  );

  typedef struct packed {
    logic        rw;
    logic [6:0]  addr;
    logic [3:0]  n;
    logic [95:0] wd;
    logic [95:0] exp_rd;
    logic [79:0] exp_ctrl;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] wbuf [12];
  logic [7:0] rbuf [12];
  logic [7:0] m_ctrl [10];
  logic [7:0] m_shadow [12];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'h0F) return 8'h6C;
    if (a >= 7'h10 && a <= 7'h19) return m_ctrl[int'(a) - 16];
    if (a >= 7'h22 && a <= 7'h2D) return m_shadow[int'(a) - 34];
    return 8'h00;
  endfunction

  function automatic logic [6:0] m_step(input logic [6:0] a);
    return AI ? a + 7'd1 : a;
  endfunction

  function automatic logic [79:0] m_pack();
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[79 - 8*i -: 8] = m_ctrl[i];
    return r;
  endfunction

  task automatic m_load_shadow(input logic [95:0] s);
    for (int k = 0; k < 12; k++) m_shadow[k] = s[95 - 8*k -: 8];
  endtask

  function automatic vec_t mk(input logic rw, input logic [6:0] addr, input int n,
                              input logic [95:0] wd, input logic [95:0] er, input logic [79:0] ec);
    vec_t v;
    v.rw = rw; v.addr = addr; v.n = 4'(n); v.wd = wd; v.exp_rd = er; v.exp_ctrl = ec;
    return v;
  endfunction

  task automatic strobe(input logic [95:0] s);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spc = 1'b0; sdi = b[i];
      repeat (HALF) @(negedge clk);
      r[i] = sdo; spc = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(output logic done);
    done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (txn_done) done = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  // strobe_at: -1 none, -2 together with the synchronized CS fall, >=0 before that data byte
  task automatic xfer(input logic rw, input logic [6:0] addr, input int n, input int strobe_at,
                      input logic [95:0] ns, output logic done);
    logic [7:0] dummy;
    cs = 1'b0;
    if (strobe_at == -2) begin
      @(negedge clk); @(negedge clk);
      strobe(ns);
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    spi_byte({rw, addr}, dummy);
    for (int j = 0; j < n; j++) begin
      if (j == strobe_at) strobe(ns);
      spi_byte(wbuf[j], rbuf[j]);
    end
    cs = 1'b1;
    wait_done(done);
  endtask

  task automatic run_model(input logic rw, input logic [6:0] addr, input int n, input int strobe_at,
                           input logic [95:0] ns, input string tag);
    logic [7:0] e [12];
    logic [6:0] a;
    logic done;
    a = addr;
    for (int j = 0; j < n; j++) begin e[j] = m_read(a); a = m_step(a); end
    xfer(rw, addr, n, strobe_at, ns, done);
    a = addr;
    for (int j = 0; j < n; j++) begin
      if (rw) check({tag, "_rd"}, 96'(rbuf[j]), 96'(e[j]));
      else if (a >= 7'h10 && a <= 7'h19) m_ctrl[int'(a) - 16] = wbuf[j];
      a = m_step(a);
    end
    check({tag, "_ctrl"}, 96'(ctrl_regs), 96'(m_pack()));
    check({tag, "_done"}, 96'(done), 96'd1);
    if (strobe_at != -1) m_load_shadow(ns);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl [11];
    logic done;
    logic [7:0] dummy, b;
    logic [95:0] ns;
    logic [6:0] ra;
    int sel, n, sa;

    rst_n = 1'b0; cs = 1'b1; spc = 1'b1; sdi = 1'b0; sample = '0; sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_sdo", 96'(sdo), 96'd0);
    check("reset_done", 96'(txn_done), 96'd0);
    check("reset_ctrl", 96'(ctrl_regs), 96'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    strobe(SEQ);
    repeat (2) @(negedge clk);

    tbl[0]  = mk(1, 7'h0F, 1, 0, {8'h6C, 88'h0}, 80'h0);
    tbl[1]  = mk(1, 7'h22, 12, 0, AI ? SEQ : {12{8'h01}}, 80'h0);
    tbl[2]  = mk(0, 7'h10, 2, {16'hAA55, 80'h0}, 0, AI ? {16'hAA55, 64'h0} : {8'h55, 72'h0});
    tbl[3]  = mk(1, 7'h10, 2, 0, AI ? {16'hAA55, 80'h0} : {16'h5555, 80'h0}, tbl[2].exp_ctrl);
    tbl[4]  = mk(0, 7'h0F, 1, {8'h12, 88'h0}, 0, tbl[2].exp_ctrl);
    tbl[5]  = mk(0, 7'h22, 1, {8'h34, 88'h0}, 0, tbl[2].exp_ctrl);
    tbl[6]  = mk(1, 7'h0F, 1, 0, {8'h6C, 88'h0}, tbl[2].exp_ctrl);
    tbl[7]  = mk(1, 7'h22, 1, 0, {8'h01, 88'h0}, tbl[2].exp_ctrl);
    tbl[8]  = mk(1, 7'h0E, 3, 0, AI ? {24'h006CAA, 72'h0} : 96'h0, tbl[2].exp_ctrl);
    tbl[9]  = mk(0, 7'h19, 2, {16'h7788, 80'h0}, 0,
                 AI ? 80'hAA550000000000000077 : 80'h55000000000000000088);
    tbl[10] = mk(1, AI ? 7'h18 : 7'h19, 2, 0, AI ? {16'h0077, 80'h0} : {16'h8888, 80'h0},
                 tbl[9].exp_ctrl);

    for (int r = 0; r < 11; r++) begin
      for (int j = 0; j < 12; j++) wbuf[j] = tbl[r].wd[95 - 8*j -: 8];
      xfer(tbl[r].rw, tbl[r].addr, int'(tbl[r].n), -1, 96'h0, done);
      for (int j = 0; j < int'(tbl[r].n); j++)
        if (tbl[r].rw) check($sformatf("tbl%0d_rd%0d", r, j), 96'(rbuf[j]), 96'(tbl[r].exp_rd[95 - 8*j -: 8]));
      check($sformatf("tbl%0d_ctrl", r), 96'(ctrl_regs), 96'(tbl[r].exp_ctrl));
      check($sformatf("tbl%0d_done", r), 96'(done), 96'd1);
    end

    for (int i = 0; i < 10; i++) m_ctrl[i] = tbl[10].exp_ctrl[79 - 8*i -: 8];
    m_load_shadow(SEQ);

    // sample arriving mid-burst stays pending until the transaction ends
    ns = {$urandom, $urandom, $urandom};
    run_model(1, 7'h22, 4, 2, ns, "mid");
    run_model(1, 7'h22, 4, -1, 96'h0, "mid_next");
    // sample coinciding with the CS fall is pending too
    ns = {$urandom, $urandom, $urandom};
    run_model(1, 7'h22, 2, -2, ns, "simul");
    run_model(1, 7'h22, 2, -1, 96'h0, "simul_next");

    // write to 0x11 aborted after 5 data bits
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h11, dummy);
    for (int i = 0; i < 5; i++) begin
      spc = 1'b0; sdi = 1'b1; repeat (HALF) @(negedge clk);
      spc = 1'b1; repeat (HALF) @(negedge clk);
    end
    cs = 1'b1;
    wait_done(done);
    check("abort_done", 96'(done), 96'd1);
    check("abort_ctrl", 96'(ctrl_regs), 96'(m_pack()));
    run_model(1, 7'h11, 1, -1, 96'h0, "after_abort_rd");
    wbuf[0] = 8'hC3;
    run_model(0, 7'h11, 1, -1, 96'h0, "after_abort_wr");

    // reset during a read of 0x10 holding 0xFF
    wbuf[0] = 8'hFF;
    run_model(0, 7'h10, 1, -1, 96'h0, "pre_rst");
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h90, dummy);
    for (int i = 0; i < 3; i++) begin
      spc = 1'b0; repeat (HALF) @(negedge clk);
      spc = 1'b1; repeat (HALF) @(negedge clk);
    end
    check("rst_pre_sdo", 96'(sdo), 96'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_sdo", 96'(sdo), 96'd0);
    check("rst_ctrl", 96'(ctrl_regs), 96'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) m_ctrl[i] = 8'h00;
    m_load_shadow(96'h0);
    repeat (HALF) @(negedge clk);
    spi_byte(8'h8F, dummy);
    spi_byte(8'h00, b);
    check("rst_nostart_sdo", 96'(b), 96'd0);
    cs = 1'b1;
    wait_done(done);
    check("rst_no_done", 96'(done), 96'd0);
    run_model(1, 7'h0F, 1, -1, 96'h0, "post_rst");
    run_model(1, 7'h22, 2, -1, 96'h0, "post_rst_shadow");

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       ra = 7'($urandom_range(16, 25));
        1:       ra = 7'($urandom_range(34, 45));
        2:       ra = 7'($urandom_range(0, 127));
        default: ra = 7'h0F;
      endcase
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < 12; j++) wbuf[j] = 8'($urandom);
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if ($urandom_range(0, 2) == 0) begin
        ns = {$urandom, $urandom, $urandom};
        strobe(ns);
        m_load_shadow(ns);
        repeat (2) @(negedge clk);
      end
      ns = {$urandom, $urandom, $urandom};
      run_model(1'($urandom_range(0, 1)), ra, n, sa, ns, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
